// File: rtl/utils_pkg.sv
// utils_pkg: types and widths shared by the debug UART receiver and its FIFO.
package utils_pkg;

    localparam int DBG_BYTE_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } dbg_rx_state_t;

endpackage

// File: rtl/dbg_rx_fifo.sv
// dbg_rx_fifo: synchronous FIFO; when full, a pop in the same cycle frees the slot for the push.
module dbg_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by count, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dbg_uart_rx.sv
// dbg_uart_rx: 8N1 debug-log UART receiver feeding a valid/ready FIFO, with end-of-line flag.
// Define DBG_UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches as frame_err.
module dbg_uart_rx
    import utils_pkg::*;
#(
    parameter int                    CLKS_PER_BIT = 868,
    parameter int                    FIFO_DEPTH   = 16,
    parameter logic [DBG_BYTE_W-1:0] EOL_CHAR     = 8'h0A
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic [DBG_BYTE_W-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          eol,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int               CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);
    localparam int               BW   = $clog2(DBG_BYTE_W);

    dbg_rx_state_t           state, state_next;
    logic                    sync1, sync2, rx_prev, rx_s;
    logic [CW-1:0]           cnt;
    logic                    cnt_clr, sample;
    logic [BW-1:0]           bit_idx;
    logic [DBG_BYTE_W-1:0]   shreg;
    logic                    parity_bad;
    logic                    push, pop, full, empty, wr_ok;

    assign rx_s = sync2;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        sample     = 1'b0;
        case (state)
            RX_IDLE: begin
                // Only a high-to-low transition starts a frame, so a held break is ignored.
                if (rx_prev && !rx_s) begin
                    state_next = RX_START;
                    cnt_clr    = 1'b1;
                end
            end
            RX_START: begin
                if (cnt == MID) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    sample  = 1'b1;
                    if (bit_idx == BW'(DBG_BYTE_W - 1)) begin
`ifdef DBG_UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef DBG_UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt == LAST) begin
                    cnt_clr    = 1'b1;
                    sample     = 1'b1;
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Returning to IDLE at the stop mid-point leaves half a bit to catch the next start edge.
                if (cnt == LAST) begin
                    cnt_clr    = 1'b1;
                    sample     = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bad <= 1'b0;
            push       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            rx_prev   <= sync2;
            push      <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == RX_START) begin
                bit_idx    <= '0;
                parity_bad <= 1'b0;
            end
            if (state == RX_DATA && sample) begin
                shreg   <= {rx_s, shreg[DBG_BYTE_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
`ifdef DBG_UART_RX_PARITY_EN
            if (state == RX_PARITY && sample) parity_bad <= (rx_s != ^shreg);
`endif
            if (state == RX_STOP && sample) begin
                if (rx_s && !parity_bad) push      <= 1'b1;
                else                     frame_err <= 1'b1;
            end
        end
    end

    // shreg holds the received byte unchanged until the next frame's first data sample.
    assign pop      = m_ready & m_valid;
    assign wr_ok    = push & (~full | pop);
    assign eol      = wr_ok & (shreg == EOL_CHAR);
    assign overflow = push & full & ~pop;
    assign m_valid  = ~empty;

    dbg_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DBG_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (push),
        .wr_data (shreg),
        .rd      (m_ready),
        .rd_data (m_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_dbg_uart_rx.sv
// tb_dbg_uart_rx: directed and randomized frames against a byte-level queue model of the receiver.
// Honors DBG_UART_RX_PARITY_EN to send 8E1 frames and exercise parity errors.
`timescale 1ns/1ps
module tb_dbg_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;
`ifdef DBG_UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rxd = 1'b1;
    logic            m_ready = 1'b0;
    logic [7:0]      m_data;
    logic            m_valid, eol, frame_err, overflow;
    logic [CNTW-1:0] fifo_count;

    int checks = 0, failures = 0;
    int eol_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, valid_cycles = 0;
    logic [7:0] last_head = '0;
    int push_tick;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    dbg_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .EOL_CHAR     (8'h0A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .eol        (eol),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always @(negedge clk) begin
        if (eol)       eol_cnt++;
        if (frame_err) ferr_cnt++;
        if (overflow)  ovf_cnt++;
        if (m_valid) begin
            valid_cycles++;
            last_head = m_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Drives one frame LSB-first from bits[0]; pop_at >= 0 raises m_ready for that single tick.
    task automatic send_raw(input logic [10:0] bits, input int pop_at);
        logic [CNTW-1:0] c0;
        c0 = fifo_count;
        push_tick = -1;
        for (int t = 0; t < NB * CPB; t++) begin
            rxd = bits[t / CPB];
            if (pop_at >= 0) m_ready = (t == pop_at);
            @(negedge clk);
            if (push_tick < 0 && fifo_count != c0) push_tick = t;
        end
        if (pop_at >= 0) m_ready = 1'b0;
        rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int pop_at);
`ifdef DBG_UART_RX_PARITY_EN
        send_raw({stop, ^d, d, 1'b0}, pop_at);
`else
        send_raw({1'b0, stop, d, 1'b0}, pop_at);
`endif
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check(tag, 32'(m_data), 32'(exp));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        int v0, e0, f0, o0, p;
        logic [7:0] partial;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_eol", 32'(eol), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        idle(2 * CPB);

        // Single byte with consumer always ready
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovf_cnt;
        m_ready = 1'b1;
        send_byte(8'h55, 1'b1, -1);
        idle(CPB);
        m_ready = 1'b0;
        check("b55_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("b55_data", 32'(last_head), 32'h55);
        check("b55_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("b55_ovf", 32'(ovf_cnt - o0), 32'd0);
        check("b55_count", 32'(fifo_count), 32'd0);

        // "OK\n" back-to-back, consumer stalled
        e0 = eol_cnt;
        send_byte(8'h4F, 1'b1, -1);
        send_byte(8'h4B, 1'b1, -1);
        send_byte(8'h0A, 1'b1, -1);
        idle(CPB);
        check("ok_count", 32'(fifo_count), 32'd3);
        check("ok_eol", 32'(eol_cnt - e0), 32'd1);
        pop_check("ok_0", 8'h4F);
        pop_check("ok_1", 8'h4B);
        pop_check("ok_2", 8'h0A);
        check("ok_empty", 32'(fifo_count), 32'd0);

        // Stop bit low
        f0 = ferr_cnt;
        send_byte(8'hA3, 1'b0, -1);
        idle(2 * CPB);
        check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);

        // Short low glitch on the idle line
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'h3C, 1'b1, -1);
        idle(CPB);
        pop_check("glitch_next", 8'h3C);

        // Overflow on the fifth byte
        o0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, -1);
        idle(CPB);
        check("ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_head%0d", i), 8'(i));

        // Pop coinciding with the write into a full FIFO
        o0 = ovf_cnt;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, -1);
        p = push_tick;
        check("simul_push_seen", 32'(p >= 0), 32'd1);
        send_byte(8'h05, 1'b1, p);
        idle(CPB);
        check("simul_ovf", 32'(ovf_cnt - o0), 32'd0);
        check("simul_count", 32'(fifo_count), 32'd4);
        for (int i = 2; i <= 5; i++) pop_check($sformatf("simul_head%0d", i), 8'(i));

        // Reset in the middle of data bit 4
        send_byte(8'h11, 1'b1, -1);
        idle(CPB);
        check("mid_pre_count", 32'(fifo_count), 32'd1);
        e0 = eol_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
        partial = 8'h96;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rxd = partial[b];
            repeat (CPB) @(negedge clk);
        end
        rxd = partial[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        idle(2 * CPB);
        check("mid_rst_pulses", 32'((eol_cnt - e0) + (ferr_cnt - f0) + (ovf_cnt - o0)), 32'd0);
        send_byte(8'h7E, 1'b1, -1);
        idle(CPB);
        check("mid_next_count", 32'(fifo_count), 32'd1);
        check("mid_next_ferr", 32'(ferr_cnt - f0), 32'd0);
        pop_check("mid_next", 8'h7E);

`ifdef DBG_UART_RX_PARITY_EN
        // 0x07 has three ones: even parity needs the parity bit set
        f0 = ferr_cnt;
        send_raw({1'b1, 1'b0, 8'h07, 1'b0}, -1);
        idle(CPB);
        check("par_bad_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("par_bad_count", 32'(fifo_count), 32'd0);
        send_raw({1'b1, 1'b1, 8'h07, 1'b0}, -1);
        idle(CPB);
        check("par_ok_ferr", 32'(ferr_cnt - f0), 32'd1);
        pop_check("par_ok", 8'h07);
`endif

        // Randomized bursts against the queue model
        for (int r = 0; r < 8; r++) begin
            int n, exp_eol, exp_ferr, exp_ovf;
            n = $urandom_range(1, 6);
            exp_eol = 0; exp_ferr = 0; exp_ovf = 0;
            e0 = eol_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                logic stop_ok, par_ok;
                d = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                stop_ok = ($urandom_range(0, 5) != 0);
                par_ok = 1'b1;
`ifdef DBG_UART_RX_PARITY_EN
                par_ok = ($urandom_range(0, 4) != 0);
                send_raw({stop_ok, par_ok ? ^d : ~^d, d, 1'b0}, -1);
`else
                send_byte(d, stop_ok, -1);
`endif
                if (!stop_ok) idle(CPB);
                if (stop_ok && par_ok) begin
                    if (model_q.size() < DEPTH) begin
                        model_q.push_back(d);
                        if (d == 8'h0A) exp_eol++;
                    end else begin
                        exp_ovf++;
                    end
                end else begin
                    exp_ferr++;
                end
            end
            idle(CPB);
            check($sformatf("rnd%0d_count", r), 32'(fifo_count), 32'(model_q.size()));
            check($sformatf("rnd%0d_eol", r), 32'(eol_cnt - e0), 32'(exp_eol));
            check($sformatf("rnd%0d_ferr", r), 32'(ferr_cnt - f0), 32'(exp_ferr));
            check($sformatf("rnd%0d_ovf", r), 32'(ovf_cnt - o0), 32'(exp_ovf));
            while (model_q.size() > 0) begin
                logic [7:0] exp_b;
                exp_b = model_q.pop_front();
                pop_check($sformatf("rnd%0d_pop", r), exp_b);
            end
            check($sformatf("rnd%0d_drained", r), 32'(m_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
